// File: rtl/score_ram_writer_if.sv
// score_ram_writer_if: score RAM write-generator handshake (init control, score input, RAM write port).
interface score_ram_writer_if #(
  parameter int BitAddr = 8,
  parameter int ADDR_W = 15,
  parameter int SCORE_W = 10
);
  logic start_init;
  logic [BitAddr:0] i;
  logic [BitAddr:0] j;
  logic signed [SCORE_W-1:0] score_in;
  logic score_valid;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic signed [SCORE_W-1:0] wr_data;
  logic init_done;
  logic busy;
  logic cell_done;
  logic drop_err;
  modport master (
    output start_init, i, j, score_in, score_valid,
    input wr_en, wr_addr, wr_data, init_done, busy, cell_done, drop_err
  );
  modport slave (
    input start_init, i, j, score_in, score_valid,
    output wr_en, wr_addr, wr_data, init_done, busy, cell_done, drop_err
  );
endinterface

// File: rtl/score_ram_writer.sv
// score_ram_writer: fills row/col 0 of the NW score RAM with gap penalties, then stores cell scores.
// Define SCORE_SAT_EN to saturate init values at -2^(SCORE_W-1) instead of wrapping.
module score_ram_writer #(
  parameter int N = 128,
  parameter int SCORE_W = 10,
  parameter int GAP = 2,
  parameter int BitAddr = $clog2(N+1),
  parameter int ADDR_W = $clog2((N+1)*(N+1))
) (
  input logic clk,
  input logic rst,
  score_ram_writer_if.slave bus
);
  localparam int PW = SCORE_W + BitAddr + 2;
  localparam logic [BitAddr:0] K_N = (BitAddr+1)'(N);
  localparam logic [BitAddr:0] K_MAX = (BitAddr+1)'(N-1);
  localparam logic [BitAddr:0] K_ONE = (BitAddr+1)'(1);
  localparam logic [ADDR_W:0] A_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ROW_LEN = (ADDR_W+1)'(N+1);
  localparam logic signed [PW-1:0] GAP_P = PW'(GAP);
  // RESTART holds off init for one cycle when a score write coincides with start_init
  typedef enum logic [2:0] {IDLE, INIT_ROW, INIT_COL, READY, RESTART} state_t;
  state_t state, nxt_state;
  logic [BitAddr:0] k, nxt_k;
  logic accept, init_wr;
  logic [ADDR_W:0] row_a, col_a, sc_a, addr_w;
  logic signed [PW-1:0] init_p;
  logic [SCORE_W-1:0] init_v;
  logic unused_ok;
  assign accept = state == READY && bus.score_valid && bus.i <= K_MAX && bus.j <= K_MAX;
  always_comb begin
    nxt_state = state;
    nxt_k = k;
    case (state)
      IDLE: begin
        nxt_state = bus.start_init ? INIT_ROW : IDLE;
        nxt_k = '0;
      end
      INIT_ROW: begin
        nxt_state = k == K_N ? INIT_COL : INIT_ROW;
        nxt_k = k == K_N ? K_ONE : k + K_ONE;
      end
      INIT_COL: begin
        nxt_state = k == K_N ? READY : INIT_COL;
        nxt_k = k == K_N ? '0 : k + K_ONE;
      end
      READY: begin
        nxt_state = !bus.start_init ? READY : accept ? RESTART : INIT_ROW;
        nxt_k = '0;
      end
      RESTART: begin
        nxt_state = INIT_ROW;
        nxt_k = '0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_k = '0;
      end
    endcase
  end
  // the write issued at the next edge belongs to the cell indexed by nxt_k
  assign init_wr = nxt_state == INIT_ROW || nxt_state == INIT_COL;
  assign row_a = (ADDR_W+1)'(nxt_k);
  assign col_a = row_a * ROW_LEN;
  assign sc_a = ((ADDR_W+1)'(bus.j) + A_ONE) + ((ADDR_W+1)'(bus.i) + A_ONE) * ROW_LEN;
  assign addr_w = accept ? sc_a : nxt_state == INIT_ROW ? row_a : col_a;
  assign init_p = -($signed(PW'(nxt_k)) * GAP_P);
`ifdef SCORE_SAT_EN
  localparam logic signed [PW-1:0] MIN_P = PW'(-(2 ** (SCORE_W-1)));
  assign init_v = init_p < MIN_P ? MIN_P[SCORE_W-1:0] : init_p[SCORE_W-1:0];
`else
  assign init_v = init_p[SCORE_W-1:0];
`endif
  assign unused_ok = &{1'b0, init_p, addr_w[ADDR_W]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.init_done <= 1'b0;
      bus.busy <= 1'b0;
      bus.cell_done <= 1'b0;
      bus.drop_err <= 1'b0;
    end else begin
      state <= nxt_state;
      k <= nxt_k;
      bus.wr_en <= accept || init_wr;
      if (accept || init_wr) bus.wr_addr <= addr_w[ADDR_W-1:0];
      if (accept || init_wr) bus.wr_data <= accept ? bus.score_in : init_v;
      bus.init_done <= nxt_state == READY;
      bus.busy <= init_wr;
      bus.cell_done <= accept;
      bus.drop_err <= bus.drop_err || (bus.score_valid && !accept);
    end
  end
endmodule

// File: tb/tb_score_ram_writer.sv
// tb_score_ram_writer: scoreboard bench for score_ram_writer (N=4, GAP=2; second instance GAP=200).
module tb_score_ram_writer;
  localparam int N = 4;
  localparam int GAP = 2;
  localparam int GAP_B = 200;
  localparam int SW = 10;
  localparam int BA = $clog2(N+1);
  localparam int AW = $clog2((N+1)*(N+1));
  typedef struct packed {
    logic [AW-1:0] a;
    logic signed [SW-1:0] d;
    logic c;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errs = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  score_ram_writer_if #(.BitAddr(BA), .ADDR_W(AW), .SCORE_W(SW)) bus();
  score_ram_writer_if #(.BitAddr(BA), .ADDR_W(AW), .SCORE_W(SW)) bus_b();
  score_ram_writer #(.N(N), .SCORE_W(SW), .GAP(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));
  score_ram_writer #(.N(N), .SCORE_W(SW), .GAP(GAP_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end
  always @(negedge clk) begin
    if (bus.wr_en) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write got addr=%0d data=%0d cell=%0b, expected none", bus.wr_addr, bus.wr_data, bus.cell_done);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.wr_addr, bus.wr_data, bus.cell_done} !== mon_e) begin
          errs++;
          $display("FAIL write got addr=%0d data=%0d cell=%0b, expected addr=%0d data=%0d cell=%0b",
                   bus.wr_addr, bus.wr_data, bus.cell_done, mon_e.a, mon_e.d, mon_e.c);
        end
      end
    end else if (bus.cell_done) begin
      vectors++;
      errs++;
      $display("FAIL cell_done_without_write got cell_done=1, expected 0");
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic push_init(input int cnt);
    for (int c = 0; c < cnt; c++) begin
      int kk = c <= N ? c : c - N;
      wr_t e;
      e.a = AW'(c <= N ? kk : (N+1) * kk);
      e.d = SW'(-(kk * GAP));
      e.c = 1'b0;
      exp_q.push_back(e);
    end
  endtask
  task automatic run_init(input int lead, input int drop_at);
    bus.start_init = 1'b1;
    push_init(2*N+1);
    tick();
    bus.start_init = 1'b0;
    bus.score_valid = 1'b0;
    for (int l = 0; l < lead; l++) begin
      vectors++;
      if (bus.init_done !== 1'b0 || bus.busy !== 1'b0) begin
        errs++;
        $display("FAIL restart_gap got init_done=%0b busy=%0b, expected 0 0", bus.init_done, bus.busy);
      end
      tick();
    end
    for (int c = 0; c < 2*N+1; c++) begin
      bus.score_valid = c == drop_at;
      vectors++;
      if (bus.wr_en !== 1'b1 || bus.busy !== 1'b1 || bus.init_done !== 1'b0) begin
        errs++;
        $display("FAIL init_cycle%0d got wr_en=%0b busy=%0b init_done=%0b, expected 1 1 0", c, bus.wr_en, bus.busy, bus.init_done);
      end
      tick();
    end
    bus.score_valid = 1'b0;
    vectors++;
    if (bus.init_done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      errs++;
      $display("FAIL init_end got init_done=%0b busy=%0b wr_en=%0b, expected 1 0 0", bus.init_done, bus.busy, bus.wr_en);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL init_pending got %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.start_init = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.init_done, bus.busy, bus.cell_done, bus.drop_err} !== '0) begin
      errs++;
      $display("FAIL reset got wr_en=%0b addr=%0d data=%0d init_done=%0b busy=%0b cell=%0b drop=%0b, expected all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.init_done, bus.busy, bus.cell_done, bus.drop_err);
    end
    bus.start_init = 1'b0;
    rst = 1'b0;
    tick();
  endtask
  task automatic test_init();
    run_init(0, -1);
  endtask
  task automatic test_score();
    bus.score_valid = 1'b1;
    bus.i = 0;
    bus.j = 0;
    bus.score_in = 10'sd3;
    exp_q.push_back('{a: AW'(6), d: 10'sd3, c: 1'b1});
    tick();
    bus.i = 3;
    bus.j = 3;
    bus.score_in = -10'sd5;
    exp_q.push_back('{a: AW'(24), d: -10'sd5, c: 1'b1});
    tick();
    bus.score_valid = 1'b0;
    tick();
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== AW'(24) || bus.wr_data !== -10'sd5 || bus.drop_err !== 1'b0) begin
      errs++;
      $display("FAIL score_hold got wr_en=%0b addr=%0d data=%0d drop=%0b, expected 0 24 -5 0", bus.wr_en, bus.wr_addr, bus.wr_data, bus.drop_err);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL score_pending got %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask
  task automatic test_range();
    bus.score_valid = 1'b1;
    bus.i = BA'(N);
    bus.j = 0;
    bus.score_in = 10'sd9;
    tick();
    bus.score_valid = 1'b0;
    vectors++;
    if (bus.drop_err !== 1'b1 || bus.wr_en !== 1'b0) begin
      errs++;
      $display("FAIL range_drop got drop=%0b wr_en=%0b, expected 1 0", bus.drop_err, bus.wr_en);
    end
    bus.i = 0;
    tick();
  endtask
  task automatic test_abort();
    bus.start_init = 1'b1;
    push_init(3);
    tick();
    bus.start_init = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.init_done !== 1'b0 || bus.busy !== 1'b0 || bus.drop_err !== 1'b0) begin
      errs++;
      $display("FAIL abort got wr_en=%0b init_done=%0b busy=%0b drop=%0b, expected 0 0 0 0", bus.wr_en, bus.init_done, bus.busy, bus.drop_err);
    end
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_idle got wr_en=%0b busy=%0b, expected 0 0", bus.wr_en, bus.busy);
    end
  endtask
  task automatic test_init_drop();
    bus.i = 0;
    bus.j = 0;
    run_init(0, N+2);
    vectors++;
    if (bus.drop_err !== 1'b1) begin
      errs++;
      $display("FAIL init_drop got drop=%0b, expected 1", bus.drop_err);
    end
  endtask
  task automatic test_restart();
    run_init(0, -1);
    vectors++;
    if (bus.drop_err !== 1'b1) begin
      errs++;
      $display("FAIL restart_sticky got drop=%0b, expected 1", bus.drop_err);
    end
  endtask
  task automatic test_back_to_back();
    bus.score_valid = 1'b1;
    bus.i = 1;
    bus.j = 2;
    bus.score_in = 10'sd7;
    exp_q.push_back('{a: AW'(13), d: 10'sd7, c: 1'b1});
    run_init(1, -1);
  endtask
  task automatic test_sat();
    bus_b.start_init = 1'b1;
    tick();
    bus_b.start_init = 1'b0;
    for (int c = 0; c < 2*N+1; c++) begin
      int kk = c <= N ? c : c - N;
      int v = -(kk * GAP_B);
      logic [SW-1:0] ev;
      logic [AW-1:0] ea;
`ifdef SCORE_SAT_EN
      if (v < -(1 << (SW-1))) v = -(1 << (SW-1));
`endif
      ev = v[SW-1:0];
      ea = AW'(c <= N ? kk : (N+1) * kk);
      vectors++;
      if (bus_b.wr_en !== 1'b1 || bus_b.wr_addr !== ea || bus_b.wr_data !== ev) begin
        errs++;
        $display("FAIL sat_k%0d got wr_en=%0b addr=%0d data=%0d, expected 1 %0d %0d",
                 kk, bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data, ea, $signed(ev));
      end
      tick();
    end
  endtask
  initial begin
    bus.start_init = 1'b0;
    bus.score_valid = 1'b0;
    bus.i = '0;
    bus.j = '0;
    bus.score_in = '0;
    bus_b.start_init = 1'b0;
    bus_b.score_valid = 1'b0;
    bus_b.i = '0;
    bus_b.j = '0;
    bus_b.score_in = '0;
    test_reset();
    test_init();
    test_score();
    test_range();
    test_abort();
    test_init_drop();
    test_restart();
    test_back_to_back();
    test_sat();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
